// File: rtl/bt_cmd_ctrl.sv
// Bluetooth command controller: synchronises decoded command levels, arbitrates edge
// events, tracks saturating volume and a wrapping song index with a req/ack handshake.
module bt_cmd_ctrl #(
  parameter int unsigned NUM_SONGS = 4,
  parameter int unsigned SONG_W    = 2,
  parameter int unsigned VOL_MAX   = 15,
  parameter int unsigned VOL_INIT  = 8,
  parameter int unsigned VOL_STEP  = 16
) (
  input  logic              ctrl_clk,
  input  logic              rst_n,
  input  logic              Bt_Inc_Vol,
  input  logic              Bt_Dec_Vol,
  input  logic              Bt_Next_Song,
  input  logic              Bt_Pre_Song,
  input  logic              Bt_Rst,
  input  logic              song_ack,
  output logic [3:0]        vol_level,
  output logic [15:0]       vol_word,
  output logic              vol_update,
  output logic [SONG_W-1:0] song_idx,
  output logic              song_req,
  output logic              soft_rst
);

  typedef enum logic [1:0] {StIdle, StReq, StGap} song_state_e;

  localparam logic [3:0]        VolMax   = 4'(VOL_MAX);
  localparam logic [3:0]        VolInit  = 4'(VOL_INIT);
  localparam logic [SONG_W-1:0] LastSong = SONG_W'(NUM_SONGS - 1);
  // Bit order {rst, pre, next, dec, inc}; remote reset is active-low so it idles high.
  localparam logic [4:0]        SyncRst  = 5'b10000;

  function automatic logic [7:0] att_of(input logic [3:0] lvl);
    logic [11:0] prod;
    prod = (12'(VOL_MAX) - 12'(lvl)) * 12'(VOL_STEP);
    return (prod > 12'd254) ? 8'd254 : prod[7:0];
  endfunction

  function automatic logic [SONG_W-1:0] idx_inc(input logic [SONG_W-1:0] i);
    return (i == LastSong) ? '0 : i + SONG_W'(1);
  endfunction

  function automatic logic [SONG_W-1:0] idx_dec(input logic [SONG_W-1:0] i);
    return (i == '0) ? LastSong : i - SONG_W'(1);
  endfunction

  localparam logic [7:0] AttInit = att_of(VolInit);

  // Input capture
  logic [4:0] raw;
  logic [4:0] sync1_q, sync2_q, prev_q;

  assign raw = {Bt_Rst, Bt_Pre_Song, Bt_Next_Song, Bt_Dec_Vol, Bt_Inc_Vol};

  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= SyncRst;
      sync2_q <= SyncRst;
      prev_q  <= SyncRst;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Edge detection and fixed-priority arbitration
  logic [3:0] rise;
  logic       ev_rst, ev_next, ev_pre, ev_inc, ev_dec, song_ev;

  assign rise    = sync2_q[3:0] & ~prev_q[3:0];
  assign ev_rst  = prev_q[4] & ~sync2_q[4];
  assign ev_next = rise[2] & ~ev_rst;
  assign ev_pre  = rise[3] & ~ev_rst & ~rise[2];
  assign ev_inc  = rise[0] & ~ev_rst & ~rise[2] & ~rise[3];
  assign ev_dec  = rise[1] & ~ev_rst & ~rise[2] & ~rise[3] & ~rise[0];
  assign song_ev = ev_next | ev_pre;

  // Volume
  logic [3:0]  vol_level_q, vol_level_d;
  logic [15:0] vol_word_q, vol_word_d;
  logic        vol_update_q, vol_update_d;
  logic        soft_rst_q;
  logic [7:0]  att_d;

  always_comb begin
    vol_level_d  = vol_level_q;
    vol_update_d = 1'b0;
    if (ev_rst) begin
      vol_level_d  = VolInit;
      vol_update_d = (vol_level_q != VolInit);
    end else if (ev_inc && (vol_level_q < VolMax)) begin
      vol_level_d  = vol_level_q + 4'd1;
      vol_update_d = 1'b1;
    end else if (ev_dec && (vol_level_q != 4'd0)) begin
      vol_level_d  = vol_level_q - 4'd1;
      vol_update_d = 1'b1;
    end
    att_d      = att_of(vol_level_d);
    vol_word_d = {att_d, att_d};
  end

  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      vol_level_q  <= VolInit;
      vol_word_q   <= {AttInit, AttInit};
      vol_update_q <= 1'b0;
      soft_rst_q   <= 1'b0;
    end else begin
      vol_level_q  <= vol_level_d;
      vol_word_q   <= vol_word_d;
      vol_update_q <= vol_update_d;
      soft_rst_q   <= ev_rst;
    end
  end

  // Song FSM; tgt_q runs ahead of song_idx while a request is outstanding.
  song_state_e       state_q, state_d;
  logic [SONG_W-1:0] idx_q, idx_d, tgt_q, tgt_d, step_idx;
  logic              pend_q, pend_d, req_q, req_d;

  assign step_idx = ev_next ? idx_inc(tgt_q) : idx_dec(tgt_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tgt_d   = tgt_q;
    pend_d  = pend_q;
    req_d   = req_q;
    if (ev_rst) begin
      state_d = StIdle;
      idx_d   = '0;
      tgt_d   = '0;
      pend_d  = 1'b0;
      req_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (song_ev) begin
            idx_d   = step_idx;
            tgt_d   = step_idx;
            req_d   = 1'b1;
            state_d = StReq;
          end
        end
        StReq: begin
          if (song_ev) begin
            tgt_d  = step_idx;
            pend_d = 1'b1;
          end
          if (song_ack) begin
            req_d   = 1'b0;
            state_d = (pend_q || song_ev) ? StGap : StIdle;
          end
        end
        StGap: begin
          tgt_d   = song_ev ? step_idx : tgt_q;
          idx_d   = tgt_d;
          req_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = StReq;
        end
        default: begin
          state_d = StIdle;
          req_d   = 1'b0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ctrl_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      tgt_q   <= '0;
      pend_q  <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
    end
  end

  assign vol_level  = vol_level_q;
  assign vol_word   = vol_word_q;
  assign vol_update = vol_update_q;
  assign song_idx   = idx_q;
  assign song_req   = req_q;
  assign soft_rst   = soft_rst_q;

endmodule

// File: tb/tb_bt_cmd_ctrl.sv
// Directed bench for bt_cmd_ctrl: volume saturation, song handshake, priority and resets.
module tb_bt_cmd_ctrl;

  logic        ctrl_clk = 1'b0;
  logic        rst_n;
  logic        Bt_Inc_Vol, Bt_Dec_Vol, Bt_Next_Song, Bt_Pre_Song, Bt_Rst, song_ack;
  logic [3:0]  vol_level;
  logic [15:0] vol_word;
  logic        vol_update;
  logic [1:0]  song_idx;
  logic        song_req;
  logic        soft_rst;

  int total = 0;
  int bad   = 0;
  int upd_cnt  = 0;
  int soft_cnt = 0;
  int base_upd, base_soft;

  bt_cmd_ctrl dut (
    .ctrl_clk     (ctrl_clk),
    .rst_n        (rst_n),
    .Bt_Inc_Vol   (Bt_Inc_Vol),
    .Bt_Dec_Vol   (Bt_Dec_Vol),
    .Bt_Next_Song (Bt_Next_Song),
    .Bt_Pre_Song  (Bt_Pre_Song),
    .Bt_Rst       (Bt_Rst),
    .song_ack     (song_ack),
    .vol_level    (vol_level),
    .vol_word     (vol_word),
    .vol_update   (vol_update),
    .song_idx     (song_idx),
    .song_req     (song_req),
    .soft_rst     (soft_rst)
  );

  always #5 ctrl_clk = ~ctrl_clk;

  always @(posedge ctrl_clk) begin
    if (vol_update) upd_cnt++;
    if (soft_rst) soft_cnt++;
  end

  task automatic tick();
    @(posedge ctrl_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0=inc 1=dec 2=next 3=pre 4=rst(low pulse); one-cycle pulse then settle
  task automatic pulse(input int which);
    case (which)
      0: Bt_Inc_Vol = 1'b1;
      1: Bt_Dec_Vol = 1'b1;
      2: Bt_Next_Song = 1'b1;
      3: Bt_Pre_Song = 1'b1;
      default: Bt_Rst = 1'b0;
    endcase
    tick();
    Bt_Inc_Vol = 1'b0; Bt_Dec_Vol = 1'b0; Bt_Next_Song = 1'b0; Bt_Pre_Song = 1'b0;
    Bt_Rst = 1'b1;
    repeat (4) tick();
  endtask

  task automatic ack_pulse();
    song_ack = 1'b1;
    tick();
    song_ack = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    Bt_Inc_Vol = 1'b0; Bt_Dec_Vol = 1'b0; Bt_Next_Song = 1'b0; Bt_Pre_Song = 1'b0;
    Bt_Rst = 1'b1; song_ack = 1'b0;
    repeat (3) tick();
    chk("rst_update", 32'(vol_update), 32'd0);
    chk("rst_soft", 32'(soft_rst), 32'd0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("idle_level", 32'(vol_level), 32'd8);
    chk("idle_word", 32'(vol_word), 32'h7070);
    chk("idle_idx", 32'(song_idx), 32'd0);
    chk("idle_req", 32'(song_req), 32'd0);
    chk("idle_pulses", 32'(upd_cnt + soft_cnt), 32'd0);

    // Held Inc level: single event, three-edge latency
    base_upd = upd_cnt;
    Bt_Inc_Vol = 1'b1;
    tick(); tick();
    chk("lat_early_upd", 32'(vol_update), 32'd0);
    chk("lat_early_level", 32'(vol_level), 32'd8);
    tick();
    chk("lat_upd", 32'(vol_update), 32'd1);
    chk("inc_level", 32'(vol_level), 32'd9);
    chk("inc_word", 32'(vol_word), 32'h6060);
    tick();
    chk("upd_one_cycle", 32'(vol_update), 32'd0);
    repeat (16) tick();
    Bt_Inc_Vol = 1'b0;
    repeat (3) tick();
    chk("hold_one_event", 32'(upd_cnt - base_upd), 32'd1);

    // Remote reset back to 8, then saturate upwards
    base_upd = upd_cnt; base_soft = soft_cnt;
    pulse(4);
    chk("srst_level", 32'(vol_level), 32'd8);
    chk("srst_soft_cnt", 32'(soft_cnt - base_soft), 32'd1);
    chk("srst_upd_cnt", 32'(upd_cnt - base_upd), 32'd1);
    base_upd = upd_cnt;
    for (int i = 0; i < 8; i++) pulse(0);
    chk("sat_hi_cnt", 32'(upd_cnt - base_upd), 32'd7);
    chk("sat_hi_level", 32'(vol_level), 32'd15);
    chk("sat_hi_word", 32'(vol_word), 32'h0000);

    for (int i = 0; i < 15; i++) pulse(1);
    chk("lo_level", 32'(vol_level), 32'd0);
    chk("lo_word", 32'(vol_word), 32'hF0F0);
    base_upd = upd_cnt;
    pulse(1);
    chk("sat_lo_cnt", 32'(upd_cnt - base_upd), 32'd0);
    chk("sat_lo_level", 32'(vol_level), 32'd0);
    chk("sat_lo_word", 32'(vol_word), 32'hF0F0);

    // Song handshake with pending re-issue
    pulse(3);
    chk("pre_wrap_idx", 32'(song_idx), 32'd3);
    chk("pre_req", 32'(song_req), 32'd1);
    pulse(2);
    pulse(2);
    chk("req_hold_idx", 32'(song_idx), 32'd3);
    chk("req_hold_req", 32'(song_req), 32'd1);
    song_ack = 1'b1;
    tick();
    song_ack = 1'b0;
    chk("gap_req", 32'(song_req), 32'd0);
    chk("gap_idx", 32'(song_idx), 32'd3);
    tick();
    chk("reissue_req", 32'(song_req), 32'd1);
    chk("reissue_idx", 32'(song_idx), 32'd1);
    ack_pulse();
    tick();
    chk("done_req", 32'(song_req), 32'd0);

    // Same-cycle Next and Inc: song wins, volume untouched
    base_upd = upd_cnt;
    Bt_Next_Song = 1'b1; Bt_Inc_Vol = 1'b1;
    repeat (3) tick();
    chk("prio_idx", 32'(song_idx), 32'd2);
    chk("prio_req", 32'(song_req), 32'd1);
    Bt_Next_Song = 1'b0; Bt_Inc_Vol = 1'b0;
    repeat (3) tick();
    chk("prio_level", 32'(vol_level), 32'd0);
    chk("prio_upd_cnt", 32'(upd_cnt - base_upd), 32'd0);
    ack_pulse();

    // Remote reset aborts an in-flight request
    for (int i = 0; i < 12; i++) pulse(0);
    chk("lvl12", 32'(vol_level), 32'd12);
    pulse(2);
    chk("next_wrap_pre_idx", 32'(song_idx), 32'd3);
    chk("inflight_req", 32'(song_req), 32'd1);
    base_soft = soft_cnt;
    Bt_Rst = 1'b0;
    repeat (3) tick();
    chk("abort_soft", 32'(soft_rst), 32'd1);
    chk("abort_upd", 32'(vol_update), 32'd1);
    chk("abort_level", 32'(vol_level), 32'd8);
    chk("abort_req", 32'(song_req), 32'd0);
    chk("abort_idx", 32'(song_idx), 32'd0);
    tick();
    chk("abort_soft_off", 32'(soft_rst), 32'd0);
    repeat (5) tick();
    Bt_Rst = 1'b1;
    repeat (4) tick();
    chk("abort_soft_cnt", 32'(soft_cnt - base_soft), 32'd1);
    ack_pulse();
    tick();
    chk("late_ack_req", 32'(song_req), 32'd0);
    chk("late_ack_idx", 32'(song_idx), 32'd0);

    // Next from 0 after abort, then asynchronous reset mid-handshake
    pulse(0);
    pulse(2);
    chk("post_abort_idx", 32'(song_idx), 32'd1);
    chk("post_abort_level", 32'(vol_level), 32'd9);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_req", 32'(song_req), 32'd0);
    chk("async_idx", 32'(song_idx), 32'd0);
    chk("async_level", 32'(vol_level), 32'd8);
    chk("async_word", 32'(vol_word), 32'h7070);
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bt_cmd_ctrl.md
# bt_cmd_ctrl

Command controller directly downstream of the Bluetooth byte decoder. It synchronises the five decoded command levels (volume up/down, next/previous song, remote reset) and turns each rising edge into exactly one command event. It maintains the saturating volume level and the volume word sent to the codec. It also maintains the wrapping song index and hands song changes to the player through a req/ack handshake with a one-deep pending slot.

## Interface
- NUM_SONGS, 4, number of tracks; song index wraps modulo NUM_SONGS
- SONG_W, 2, width of song_idx; must satisfy 2^SONG_W >= NUM_SONGS
- VOL_MAX, 15, maximum vol_level; must be <= 15
- VOL_INIT, 8, vol_level after reset or soft reset
- VOL_STEP, 16, attenuation per level below VOL_MAX, in codec units
- ctrl_clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Bt_Inc_Vol  in  1  level, high while the last byte was "volume up"
- Bt_Dec_Vol  in  1  level, "volume down"
- Bt_Next_Song  in  1  level, "next song"
- Bt_Pre_Song  in  1  level, "previous song"
- Bt_Rst  in  1  level, active-low remote reset request
- song_ack  in  1  one-cycle pulse from the player accepting song_idx
- vol_level  out  4  current volume level, 0..VOL_MAX
- vol_word  out  16  codec volume word {att, att}, att 8 bit
- vol_update  out  1  one-cycle pulse when vol_word changes
- song_idx  out  SONG_W  song index presented to the player
- song_req  out  1  song-change request; held until song_ack
- soft_rst  out  1  one-cycle pulse on a remote reset

## Operation
**Input capture**
- All five inputs pass through 2-flop synchronisers.
- Inc/Dec/Next/Pre synchronisers reset to 0. The Bt_Rst synchroniser resets to 1, so no false event comes out of reset.
- A further register holds the previous synchronised value for edge detection.
- Event = synchronised value rising (0->1). For Bt_Rst the event is falling (1->0).
- Holding a level generates no further events. A repeated identical byte keeps the decoded level high, so it yields one event only.

**Arbitration**
- At most one event is processed per cycle.
- Priority: Rst > Next > Pre > Inc > Dec.
- Lower-priority events detected in the same cycle are discarded.

**Volume**
- Inc: if vol_level < VOL_MAX, increment and pulse vol_update. At VOL_MAX, no change and no pulse.
- Dec: if vol_level > 0, decrement and pulse vol_update. At 0, no change and no pulse.
- att = min((VOL_MAX - vol_level) * VOL_STEP, 254). Compute with at least 12 bits before clamping.
- vol_word = {att[7:0], att[7:0]}, registered in the same edge as vol_level.

**Song**
- tgt_idx is an internal target. In S_IDLE, tgt_idx equals song_idx.
- Next: tgt_idx + 1, wrapping from NUM_SONGS-1 to 0.
- Pre: tgt_idx - 1, wrapping from 0 to NUM_SONGS-1.

**Song FSM**
- S_IDLE: on a Next/Pre event, song_idx <= new target, song_req <= 1, go to S_REQ.
- S_REQ: song_req = 1 and song_idx is held stable.
  - A Next/Pre event updates tgt_idx and sets pending.
  - On song_ack, drop song_req.
  - After song_ack: if pending or an event is in the same cycle, go to S_GAP; else go to S_IDLE.
- S_GAP: song_req = 0 for exactly one cycle. Then song_idx <= tgt_idx, song_req <= 1, pending <= 0, go to S_REQ.
- An event arriving in S_GAP updates tgt_idx and is included in the re-issue.
- song_ack outside S_REQ is ignored.

**Soft reset (Bt_Rst event)**
- soft_rst pulses for one cycle.
- vol_level <= VOL_INIT; vol_update pulses if the level changed.
- song_idx <= 0, tgt_idx <= 0, pending <= 0, song_req <= 0, FSM to S_IDLE. An in-flight request is aborted.

## Timing
- Reset values:
  - vol_level = VOL_INIT
  - vol_word = {att(VOL_INIT), att(VOL_INIT)}; with defaults, 16'h7070
  - vol_update = 0, song_idx = 0, song_req = 0, soft_rst = 0
  - FSM = S_IDLE, pending = 0
- Latency: an input first sampled high at edge k updates the outputs at edge k+2. That is 3 edges, all outputs registered.
- Handshake: song_req rises together with the new song_idx. song_req falls on the edge after song_ack is sampled. Minimum low time is one cycle between consecutive requests.
- vol_update, soft_rst: exactly one cycle high per event. Never high during reset.
- Asserting rst_n low mid-handshake returns all outputs to their reset values immediately (asynchronous).

## Test plan
- Reset, then idle 10 cycles -> vol_level=8, vol_word=16'h7070, song_idx=0, song_req=0, no pulses.
- Bt_Inc_Vol high for 20 cycles -> one vol_update, 3 edges after sampling; vol_level=9, vol_word=16'h6060. 8 separate pulses from level 8 -> level 15, vol_word=0, only 7 vol_update pulses.
- From vol_level=0, one Dec event -> no vol_update, vol_level stays 0, vol_word=16'hF0F0.
- Pre event at song_idx=0 -> song_idx=3, song_req=1. Hold ack low, send Next twice -> song_idx stays 3. Pulse song_ack -> song_req low one cycle, then song_idx=1, song_req=1.
- Same-cycle synchronised edges on Bt_Next_Song and Bt_Inc_Vol (forced) -> song event only; vol_level unchanged.
- In S_REQ with vol_level=12, Bt_Rst low -> soft_rst one pulse, vol_update one pulse, vol_level=8, song_req=0, song_idx=0. A later song_ack is ignored.
